reset_seq_ctrl: RTL and testbench
=================================

# reset_seq_ctrl

Reset release sequencer for the flop banks in the design. Each bank's flops are asynchronously reset by a per-domain active-low reset. This block asserts every domain reset asynchronously and releases the domains one at a time, in index order, after a synchronized hold period. Each domain must acknowledge before the next is released, with a timeout on every acknowledge. A software-requested re-reset restarts the sequence.

## Interface
- N_DOMAINS, 4: number of sequenced reset domains; must be at least 1.
- SYNC_STAGES, 2: reset_n deassertion synchronizer depth; must be at least 2.
- HOLD_CYCLES, 8: cycles all domains stay in reset before the first release; must be at least 1.
- GAP_CYCLES, 4: cycles between one domain's ack and the next domain's release; must be at least 1.
- ACK_TIMEOUT, 16: maximum cycles to wait for a domain ack; must be at least 1.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- sw_reset_req  in  1  single-cycle re-reset request; synchronous to clk.
- dom_ack  in  N_DOMAINS  per-domain "out of reset and ready"; synchronous to clk.
- dom_reset_n  out  N_DOMAINS  per-domain active-low reset, registered.
- busy  out  1  high while a sequence is in progress.
- seq_done  out  1  high when all domains are released and acknowledged.
- err_timeout  out  1  sticky; high when an ack timeout occurred.
- err_domain  out  max(1,$clog2(N_DOMAINS))  index of the domain that timed out.

## Operation
- States and their outputs:
  - IDLE: waits for the synchronized reset.
  - HOLD: counts HOLD_CYCLES.
  - WAIT_ACK: waits on dom_ack[idx] for at most ACK_TIMEOUT cycles.
  - GAP: counts GAP_CYCLES.
  - DONE: seq_done=1.
  - ERROR: err_timeout=1.
- busy is high in IDLE, HOLD, WAIT_ACK and GAP.
- While reset_n=0, all outputs are held at their reset values:
  - dom_reset_n=0 (all domains), seq_done=0, err_timeout=0, err_domain=0, busy=1.
  - state=IDLE, idx=0.
- IDLE→HOLD on the first edge at which the synchronizer output is high.
- HOLD→WAIT_ACK after HOLD_CYCLES edges. On that edge, dom_reset_n[0] goes to 1 and idx=0.
- In WAIT_ACK:
  - If dom_ack[idx] is sampled high and idx=N_DOMAINS-1, go to DONE.
  - If dom_ack[idx] is sampled high otherwise, go to GAP.
  - Only dom_ack[idx] matters; all other ack bits are ignored.
- GAP→WAIT_ACK after GAP_CYCLES edges. On that edge, idx increments and dom_reset_n[idx] goes to 1.
- Timeout: if ACK_TIMEOUT sampling edges pass without an ack, go to ERROR with err_domain=idx.
  - If an ack arrives on the final timeout edge, the ack wins.
  - In ERROR, domains already released stay released; unreleased domains stay in reset.
- sw_reset_req is accepted only in DONE or ERROR. On acceptance:
  - Next edge: all dom_reset_n=0, seq_done=0, err_timeout=0, err_domain=0, idx=0, state=HOLD.
  - The synchronizer is not re-run.
- sw_reset_req is ignored in IDLE, HOLD, WAIT_ACK and GAP.
- An ack with N_DOMAINS=1 goes straight to DONE; GAP is never entered.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES,ACK_TIMEOUT)+1). The counter is cleared on every state entry, and counts saturate with no wrap.

## Timing
- reset_n assertion forces dom_reset_n to 0 asynchronously, with no clock required; the flop async clears drive the outputs.
- After reset_n deasserts, the synchronizer output rises on the SYNC_STAGES-th edge. The FSM enters HOLD on the next edge, E = SYNC_STAGES+1.
- dom_reset_n[0] rises at edge E+HOLD_CYCLES.
- With an ack present on every first cycle, domain k+1 releases 1+GAP_CYCLES edges after domain k.
- seq_done rises one edge after the last domain's release.
- Reset asserted mid-sequence (any state) aborts immediately to the reset values. The full sequence restarts on deassertion.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Package reset_seq_pkg holds:
  - the state enum typedef (IDLE, HOLD, WAIT_ACK, GAP, DONE, ERROR);
  - a cnt_width() constant function.
- Sub-module reset_sync: SYNC_STAGES-deep synchronizer with async assert and synchronous deassert, instantiated once on reset_n.

## Test plan
1. Defaults, reset_n released, dom_ack tied to all ones:
   - dom_reset_n[0..3] rise at edges 11, 16, 21, 26.
   - seq_done rises at edge 27; busy falls at edge 27.
2. Defaults, dom_ack[2] never asserts:
   - err_timeout=1 and err_domain=2, 16 edges after dom_reset_n[2] rises.
   - dom_reset_n = 4'b0111 and stays there.
3. Ack boundary, dom_ack[1] asserted exactly on the 16th sampling edge of WAIT_ACK:
   - No error; GAP is entered.
   - Ack asserted on the 17th edge instead: ERROR with err_domain=1.
4. From DONE, pulse sw_reset_req:
   - Next edge: dom_reset_n=4'b0000, seq_done=0.
   - dom_reset_n[0] rises 8 edges later.
   - A pulse of sw_reset_req during HOLD has no effect.
5. Assert reset_n in GAP after domain 1 is released:
   - dom_reset_n=0 with no clock edge; all outputs at their reset values.
   - After deassertion, the test 1 timing repeats exactly.
6. N_DOMAINS=1 with ack present: seq_done rises one edge after dom_reset_n[0] rises; err_domain stays 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset release sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    WAIT_ACK = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  // One counter serves all timed states, so it is sized for the longest period.
  function automatic int cnt_width(input int hold_c, input int gap_c, input int ack_c);
    int m;
    m = (gap_c > hold_c) ? gap_c : hold_c;
    m = (ack_c > m) ? ack_c : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_reset_n
);

  logic [STAGES-1:0] sync_r;

  // Shift chain filling with ones once reset_n is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], 1'b1};
    end
  end

  assign sync_reset_n = sync_r[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Releases per-domain resets one at a time in index order, waiting for each
// domain's ack (with timeout) before moving on to the next.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sw_reset_req,
  input  logic [N_DOMAINS-1:0] dom_ack,
  output logic [N_DOMAINS-1:0] dom_reset_n,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 err_timeout,
  output logic [((N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1)-1:0] err_domain
);

  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);

  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic                 sync_reset_n_s;

  logic [N_DOMAINS-1:0] dom_reset_n_r, dom_reset_n_nxt_s, rel_mask_s;
  logic                 busy_r, busy_nxt_s;
  logic                 seq_done_r, seq_done_nxt_s;
  logic                 err_timeout_r, err_timeout_nxt_s;
  logic [IDX_W-1:0]     err_domain_r, err_domain_nxt_s;

  reset_sync #(.STAGES(SYNC_STAGES)) u_reset_sync (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_reset_n (sync_reset_n_s)
  );

  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);

  // State, phase counter and domain index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state logic; the counter restarts from zero on every state entry.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_inc_s;
    idx_nxt_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (sync_reset_n_s) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = '0;
          idx_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = '0;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt_s = WAIT_ACK;
          cnt_nxt_s   = '0;
          idx_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      WAIT_ACK: begin
        // An ack on the final timeout edge still counts as success.
        if (dom_ack[idx_r]) begin
          state_nxt_s = (idx_r == IDX_W'(N_DOMAINS - 1)) ? DONE : GAP;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_nxt_s = ERROR;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      GAP: begin
        if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
          state_nxt_s = WAIT_ACK;
          cnt_nxt_s   = '0;
          idx_nxt_s   = idx_r + IDX_W'(1);
        end else begin
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      DONE, ERROR: begin
        if (sw_reset_req) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = '0;
          idx_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = '0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // Output values derived from the upcoming state so the flops line up with it.
  always_comb begin
    rel_mask_s        = '0;
    dom_reset_n_nxt_s = '0;
    busy_nxt_s        = 1'b1;
    seq_done_nxt_s    = 1'b0;
    err_timeout_nxt_s = 1'b0;
    err_domain_nxt_s  = '0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      rel_mask_s[i] = (i <= int'(idx_nxt_s));
    end
    case (state_nxt_s)
      WAIT_ACK, GAP: begin
        dom_reset_n_nxt_s = rel_mask_s;
      end
      DONE: begin
        dom_reset_n_nxt_s = rel_mask_s;
        busy_nxt_s        = 1'b0;
        seq_done_nxt_s    = 1'b1;
      end
      ERROR: begin
        dom_reset_n_nxt_s = rel_mask_s;
        busy_nxt_s        = 1'b0;
        err_timeout_nxt_s = 1'b1;
        err_domain_nxt_s  = idx_nxt_s;
      end
      default: begin
        dom_reset_n_nxt_s = '0;
      end
    endcase
  end

  // Output registers; reset_n clears them with no clock needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dom_reset_n_r <= '0;
      busy_r        <= 1'b1;
      seq_done_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      err_domain_r  <= '0;
    end else begin
      dom_reset_n_r <= dom_reset_n_nxt_s;
      busy_r        <= busy_nxt_s;
      seq_done_r    <= seq_done_nxt_s;
      err_timeout_r <= err_timeout_nxt_s;
      err_domain_r  <= err_domain_nxt_s;
    end
  end

  assign dom_reset_n = dom_reset_n_r;
  assign busy        = busy_r;
  assign seq_done    = seq_done_r;
  assign err_timeout = err_timeout_r;
  assign err_domain  = err_domain_r;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Self-checking bench for reset_seq_ctrl: timing tables plus hand-written corner sequences.
module tb_reset_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [3:0] dom_ack = 4'b0000;
  logic [3:0] dom_reset_n;
  logic       busy, seq_done, err_timeout;
  logic [1:0] err_domain;

  logic       dom1_ack = 1'b1;
  logic [0:0] dom1_reset_n;
  logic       busy1, seq_done1, err_timeout1;
  logic [0:0] err_domain1;

  always #5 clk = ~clk;

  reset_seq_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw_reset_req (sw_reset_req),
    .dom_ack      (dom_ack),
    .dom_reset_n  (dom_reset_n),
    .busy         (busy),
    .seq_done     (seq_done),
    .err_timeout  (err_timeout),
    .err_domain   (err_domain)
  );

  reset_seq_ctrl #(.N_DOMAINS(1)) dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw_reset_req (1'b0),
    .dom_ack      (dom1_ack),
    .dom_reset_n  (dom1_reset_n),
    .busy         (busy1),
    .seq_done     (seq_done1),
    .err_timeout  (err_timeout1),
    .err_domain   (err_domain1)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] ack;
    logic [3:0] dom;
    logic       done;
    logic       busy;
    logic       err;
    logic [1:0] edom;
  } vec_t;

  vec_t vecs [0:15];
  vec_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Hold reset a few cycles, then release just after an edge; next edge is edge 1.
  task automatic start_seq();
    reset_n      = 1'b0;
    sw_reset_req = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  task automatic expect_at(input vec_t v);
    vec_t e;
    sb_q.push_back(v);
    while (edge_n < v.edge_n) step();
    e = sb_q.pop_front();
    check("dom_reset_n", 32'(dom_reset_n), 32'(e.dom));
    check("seq_done", 32'(seq_done), 32'(e.done));
    check("busy", 32'(busy), 32'(e.busy));
    check("err_timeout", 32'(err_timeout), 32'(e.err));
    check("err_domain", 32'(err_domain), 32'(e.edom));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      dom_ack = vecs[i].ack;
      expect_at(vecs[i]);
    end
  endtask

  function automatic vec_t mk(input int e, input logic [3:0] d, input logic dn,
                              input logic b, input logic er, input logic [1:0] ed);
    vec_t v;
    v.edge_n = e; v.ack = 4'hF; v.dom = d; v.done = dn; v.busy = b; v.err = er; v.edom = ed;
    return v;
  endfunction

  initial begin
    // All acks present: releases at 11/16/21/26, done at 27.
    vecs[0]  = '{0,  4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{10, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{11, 4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{15, 4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{16, 4'hF, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{20, 4'hF, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{21, 4'hF, 4'h7, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{25, 4'hF, 4'h7, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{26, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{27, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{30, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0};
    // dom_ack[2] never arrives: timeout 16 edges after its release at 21.
    vecs[11] = '{0,  4'hB, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[12] = '{21, 4'hB, 4'h7, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[13] = '{36, 4'hB, 4'h7, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[14] = '{37, 4'hB, 4'h7, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[15] = '{45, 4'hB, 4'h7, 1'b0, 1'b0, 1'b1, 2'd2};

    // Test 1 and 6 (single-domain instance runs alongside).
    start_seq();
    check("n1_reset_busy", 32'(busy1), 32'd1);
    run_rows(0, 1);
    check("n1_dom_e10", 32'(dom1_reset_n), 32'd0);
    run_rows(2, 2);
    check("n1_dom_e11", 32'(dom1_reset_n), 32'd1);
    check("n1_done_e11", 32'(seq_done1), 32'd0);
    step();
    check("n1_done_e12", 32'(seq_done1), 32'd1);
    check("n1_busy_e12", 32'(busy1), 32'd0);
    check("n1_err_domain", 32'(err_domain1), 32'd0);
    check("n1_err_timeout", 32'(err_timeout1), 32'd0);
    run_rows(3, 10);

    // Test 2: timeout on domain 2.
    start_seq();
    run_rows(11, 15);

    // Test 3a: dom_ack[1] only on the 16th sampling edge (edge 32) -> GAP.
    start_seq();
    dom_ack = 4'b1101;
    while (edge_n < 31) step();
    dom_ack = 4'b1111;
    expect_at(mk(32, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0));
    dom_ack = 4'b1101;
    expect_at(mk(35, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0));
    expect_at(mk(36, 4'h7, 1'b0, 1'b1, 1'b0, 2'd0));

    // Test 3b: ack on the 17th edge is too late.
    start_seq();
    dom_ack = 4'b1101;
    expect_at(mk(31, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0));
    expect_at(mk(32, 4'h3, 1'b0, 1'b0, 1'b1, 2'd1));
    dom_ack = 4'b1111;
    expect_at(mk(33, 4'h3, 1'b0, 1'b0, 1'b1, 2'd1));
    expect_at(mk(40, 4'h3, 1'b0, 1'b0, 1'b1, 2'd1));

    // Test 4: software re-reset from DONE, with an ignored pulse during HOLD.
    start_seq();
    run_rows(0, 10);
    sw_reset_req = 1'b1;
    expect_at(mk(31, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0));
    sw_reset_req = 1'b0;
    while (edge_n < 33) step();
    sw_reset_req = 1'b1;
    expect_at(mk(34, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0));
    sw_reset_req = 1'b0;
    expect_at(mk(38, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0));
    expect_at(mk(39, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0));
    expect_at(mk(54, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0));
    expect_at(mk(55, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0));

    // Test 5: reset asserted in GAP after domain 1 release, then full rerun.
    start_seq();
    dom_ack = 4'hF;
    expect_at(mk(18, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0));
    #3 reset_n = 1'b0;
    #1;
    check("async_dom_reset_n", 32'(dom_reset_n), 32'd0);
    check("async_seq_done", 32'(seq_done), 32'd0);
    check("async_busy", 32'(busy), 32'd1);
    check("async_err_timeout", 32'(err_timeout), 32'd0);
    check("async_err_domain", 32'(err_domain), 32'd0);
    start_seq();
    run_rows(0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
